mmu_tile_sequencer: RTL and testbench

Job-level controller that drives one 4x4 systolic MMU through a complete output-tile computation: clear, optional bias preload, K streamed operand beats, skew drain, busy wait and result hand-off. It sits between the operand buffers and the MMU's command/data ports. It owns every `mmu_cmd` the array sees, so software and the DMA never issue array commands directly.

---
 rtl/mmu_tile_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_mmu_tile_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_tile_sequencer.sv
// mmu_tile_sequencer
//
// Job-level controller for one 4x4 systolic MMU. A job clears the array,
// optionally preloads per-PE bias values, streams K operand beats as
// TRIGGER/TRIGGER_LAST commands, drains the skew with six FORWARD commands,
// waits for the array to go idle and then hands the captured tile result out.
// This block is the only source of array commands.
//
// Optional feature macro: MMU_SEQ_PRELOAD_EN
//   defined   -> one PRELOAD cycle after CLEAR issues SET_PE_VAL with the
//                job bias values, so accumulation starts from the bias.
//   undefined -> no PRELOAD state, job_bias_i ignored, mmu_param_o is 0.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   job_valid_i/job_ready_o job handshake (ready only in IDLE)
//   job_k_i                 inner dimension K, sampled on job handshake
//   job_bias_i              PE initial values, PE n = r*4+c at [n*DW +: DW]
//   op_valid_i/op_ready_o   operand beat handshake
//   op_data_i/op_weight_i   row / column operand lanes
//   mmu_cmd_valid_o         command strobe to the MMU
//   mmu_cmd_o               RESET=0 TRIGGER=1 TRIGGER_LAST=2 SET_PE_VAL=5 FORWARD=8
//   mmu_data_o/weight_o     operand lanes to the array
//   mmu_param_o             {param_4, param_3, param_2, param_1}
//   mmu_busy_i, mmu_rdata_i array status and result read-back
//   res_valid_o/res_ready_i result handshake
//   res_data_o              captured mmu_rdata_i
//   seq_busy_o              high whenever a job is in progress
module mmu_tile_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ACLEN      = 4,
  parameter int KLEN_W     = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [KLEN_W-1:0]          job_k_i,
  input  logic [16*DATA_WIDTH-1:0]   job_bias_i,
  input  logic                       op_valid_i,
  output logic                       op_ready_o,
  input  logic [4*DATA_WIDTH-1:0]    op_data_i,
  input  logic [4*DATA_WIDTH-1:0]    op_weight_i,
  output logic                       mmu_cmd_valid_o,
  output logic [ACLEN:0]             mmu_cmd_o,
  output logic [4*DATA_WIDTH-1:0]    mmu_data_o,
  output logic [4*DATA_WIDTH-1:0]    mmu_weight_o,
  output logic [16*DATA_WIDTH-1:0]   mmu_param_o,
  input  logic                       mmu_busy_i,
  input  logic [16*DATA_WIDTH-1:0]   mmu_rdata_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [16*DATA_WIDTH-1:0]   res_data_o,
  output logic                       seq_busy_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
`ifdef MMU_SEQ_PRELOAD_EN
  localparam logic [2:0] S_PRELOAD = 3'd2;
`endif
  localparam logic [2:0] S_STREAM  = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_RESULT  = 3'd6;

  localparam logic [ACLEN:0] CMD_RESET        = (ACLEN+1)'(0);
  localparam logic [ACLEN:0] CMD_TRIGGER      = (ACLEN+1)'(1);
  localparam logic [ACLEN:0] CMD_TRIGGER_LAST = (ACLEN+1)'(2);
`ifdef MMU_SEQ_PRELOAD_EN
  localparam logic [ACLEN:0] CMD_SET_PE_VAL   = (ACLEN+1)'(5);
`endif
  localparam logic [ACLEN:0] CMD_FORWARD      = (ACLEN+1)'(8);

  // Skew drain length for a 4x4 array: 2*(4-1) FORWARD commands.
  localparam logic [2:0] DRAIN_LAST = 3'd5;

  logic [2:0]        state;
  logic [KLEN_W-1:0] k_cnt;
  logic [2:0]        drain_cnt;
  logic              beat;

  assign beat = op_valid_i && op_ready_o;

`ifdef MMU_SEQ_PRELOAD_EN
  logic [16*DATA_WIDTH-1:0] bias_q;
  logic [16*DATA_WIDTH-1:0] bias_repacked;

  // PE (r,c) is loaded through the param port of column c, slice r, while
  // the job bias bus is ordered row-major (PE n = r*4+c).
  always_comb begin
    bias_repacked = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        bias_repacked[(c*4+r)*DATA_WIDTH +: DATA_WIDTH] =
          job_bias_i[(r*4+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
`else
  logic unused_bias;
  assign unused_bias = ^job_bias_i;
  assign mmu_param_o = '0;
`endif

  // Single registered FSM: command outputs default to an idle bus every
  // cycle and are only raised by the state that owns the next command slot,
  // so every output is a flop and nothing leaks between states.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= S_IDLE;
      k_cnt           <= '0;
      drain_cnt       <= '0;
      job_ready_o     <= 1'b1;
      op_ready_o      <= 1'b0;
      mmu_cmd_valid_o <= 1'b0;
      mmu_cmd_o       <= CMD_RESET;
      mmu_data_o      <= '0;
      mmu_weight_o    <= '0;
      res_valid_o     <= 1'b0;
      res_data_o      <= '0;
      seq_busy_o      <= 1'b0;
`ifdef MMU_SEQ_PRELOAD_EN
      mmu_param_o     <= '0;
      bias_q          <= '0;
`endif
    end else begin
      mmu_cmd_valid_o <= 1'b0;
      mmu_cmd_o       <= CMD_RESET;
      mmu_data_o      <= '0;
      mmu_weight_o    <= '0;
`ifdef MMU_SEQ_PRELOAD_EN
      mmu_param_o     <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (job_valid_i) begin
            k_cnt           <= job_k_i;
            job_ready_o     <= 1'b0;
            seq_busy_o      <= 1'b1;
            mmu_cmd_valid_o <= 1'b1;
            mmu_cmd_o       <= CMD_RESET;
`ifdef MMU_SEQ_PRELOAD_EN
            bias_q          <= bias_repacked;
`endif
            state           <= S_CLEAR;
          end
        end
`ifdef MMU_SEQ_PRELOAD_EN
        S_CLEAR: begin
          mmu_cmd_valid_o <= 1'b1;
          mmu_cmd_o       <= CMD_SET_PE_VAL;
          mmu_param_o     <= bias_q;
          state           <= S_PRELOAD;
        end
        S_PRELOAD: begin
          if (k_cnt == '0) begin
            state <= S_WAIT;
          end else begin
            op_ready_o <= 1'b1;
            state      <= S_STREAM;
          end
        end
`else
        // K==0 skips streaming entirely so k_cnt can never wrap.
        S_CLEAR: begin
          if (k_cnt == '0) begin
            state <= S_WAIT;
          end else begin
            op_ready_o <= 1'b1;
            state      <= S_STREAM;
          end
        end
`endif
        S_STREAM: begin
          if (beat) begin
            mmu_cmd_valid_o <= 1'b1;
            mmu_cmd_o       <= (k_cnt == KLEN_W'(1)) ? CMD_TRIGGER_LAST : CMD_TRIGGER;
            mmu_data_o      <= op_data_i;
            mmu_weight_o    <= op_weight_i;
            k_cnt           <= k_cnt - KLEN_W'(1);
            if (k_cnt == KLEN_W'(1)) begin
              op_ready_o <= 1'b0;
              drain_cnt  <= '0;
              state      <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          mmu_cmd_valid_o <= 1'b1;
          mmu_cmd_o       <= CMD_FORWARD;
          drain_cnt       <= drain_cnt + 3'd1;
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_WAIT;
          end
        end
        // A command still on the bus means the array has not seen it yet,
        // so its busy flag cannot be trusted in that cycle.
        S_WAIT: begin
          if (!mmu_busy_i && !mmu_cmd_valid_o) begin
            res_data_o  <= mmu_rdata_i;
            res_valid_o <= 1'b1;
            state       <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            job_ready_o <= 1'b1;
            seq_busy_o  <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_tile_sequencer.sv
// Testbench for mmu_tile_sequencer: a small behavioural MMU model accumulates
// the issued commands, and directed job vectors are compared against
// hand-computed tile results, latencies and command counts.
module tb_mmu_tile_sequencer;

  localparam int DW = 32;
`ifdef MMU_SEQ_PRELOAD_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic            clk;
  logic            rst_n;
  logic            job_valid;
  logic            job_ready;
  logic [15:0]     job_k;
  logic [16*DW-1:0] job_bias;
  logic            op_valid;
  logic            op_ready;
  logic [4*DW-1:0] op_data;
  logic [4*DW-1:0] op_weight;
  logic            cmd_valid;
  logic [4:0]      cmd;
  logic [4*DW-1:0] mmu_data;
  logic [4*DW-1:0] mmu_weight;
  logic [16*DW-1:0] mmu_param;
  logic            mmu_busy;
  logic [16*DW-1:0] mmu_rdata;
  logic            res_valid;
  logic            res_ready;
  logic [16*DW-1:0] res_data;
  logic            seq_busy;

  mmu_tile_sequencer dut (
    .clk_i(clk), .rst_i(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_k_i(job_k),
    .job_bias_i(job_bias),
    .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_data_i(op_data), .op_weight_i(op_weight),
    .mmu_cmd_valid_o(cmd_valid), .mmu_cmd_o(cmd),
    .mmu_data_o(mmu_data), .mmu_weight_o(mmu_weight), .mmu_param_o(mmu_param),
    .mmu_busy_i(mmu_busy), .mmu_rdata_i(mmu_rdata),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .seq_busy_o(seq_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: acc[r][c] += data[r]*weight[c] per trigger.
  logic [31:0] acc [4][4];

  always @(posedge clk) begin
    if (cmd_valid) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          case (cmd)
            5'd0:       acc[r][c] <= 32'd0;
            5'd1, 5'd2: acc[r][c] <= acc[r][c] + mmu_data[r*DW +: DW] * mmu_weight[c*DW +: DW];
            5'd5:       acc[r][c] <= mmu_param[(c*4+r)*DW +: DW];
            default:    acc[r][c] <= acc[r][c];
          endcase
        end
      end
    end
  end

  always_comb begin
    mmu_rdata = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mmu_rdata[(c*4+r)*DW +: DW] = acc[r][c];
      end
    end
  end

  // Command bus monitor.
  int cnt_hs, cnt_opr, cnt_r, cnt_t, cnt_tl, cnt_s, cnt_f, bad_gap, bad_fwd;
  logic prev_hs;

  initial begin
    cnt_hs = 0; cnt_opr = 0; cnt_r = 0; cnt_t = 0; cnt_tl = 0;
    cnt_s = 0; cnt_f = 0; bad_gap = 0; bad_fwd = 0; prev_hs = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_hs <= 1'b0;
    end else begin
      prev_hs <= op_valid && op_ready;
      if (op_valid && op_ready) cnt_hs <= cnt_hs + 1;
      if (op_ready) cnt_opr <= cnt_opr + 1;
      if (cmd_valid) begin
        case (cmd)
          5'd0: cnt_r  <= cnt_r + 1;
          5'd1: cnt_t  <= cnt_t + 1;
          5'd2: cnt_tl <= cnt_tl + 1;
          5'd5: cnt_s  <= cnt_s + 1;
          5'd8: begin
            cnt_f <= cnt_f + 1;
            if ((mmu_data != '0) || (mmu_weight != '0)) bad_fwd <= bad_fwd + 1;
          end
          default: bad_fwd <= bad_fwd + 1;
        endcase
      end
      if ((cmd_valid && (cmd == 5'd1 || cmd == 5'd2) && !prev_hs) || (!cmd_valid && prev_hs))
        bad_gap <= bad_gap + 1;
    end
  end

  int n_pass, n_total;

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check_int({tag, "_ctrl"}, int'({job_ready, op_ready, cmd_valid, seq_busy, res_valid}), 16);
    check_int({tag, "_cmd"}, int'(cmd), 0);
    check_vec({tag, "_mmu_dw"}, 512'({mmu_data, mmu_weight}), '0);
    check_vec({tag, "_param"}, mmu_param, '0);
    check_vec({tag, "_res_data"}, res_data, '0);
  endtask

  typedef struct {
    int               k;
    logic [3:0][31:0] d;
    logic [3:0][31:0] w;
    bit               stall;
    int               ready_delay;
    int               busy_rel;
    logic [15:0][31:0] exp;
    int               lat;
  } vec_t;

  vec_t vecs [7];

  task automatic run_job(input vec_t v, input int id);
    int b_hs, b_opr, b_r, b_t, b_tl, b_s, b_f, b_bad;
    int lat, unstable;
    bit phase;
    logic [511:0] held;
    string nm;
    nm = $sformatf("job%0d", id);
    @(negedge clk);
    b_hs = cnt_hs; b_opr = cnt_opr; b_r = cnt_r; b_t = cnt_t; b_tl = cnt_tl;
    b_s = cnt_s; b_f = cnt_f; b_bad = bad_gap + bad_fwd;
    job_k     = 16'(v.k);
    op_data   = v.d;
    op_weight = v.w;
    mmu_busy  = (v.busy_rel > 0);
    job_valid = 1'b1;
    lat = 0;
    while (!job_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_int({nm, "_accept"}, int'(job_ready), 1);
    @(negedge clk);
    job_valid = 1'b0;
    lat = 1;
    check_int({nm, "_reset_cmd"}, int'({cmd_valid, cmd}), 32);
    phase = 1'b1;
    while (!res_valid && lat < 400) begin
      op_valid = ((cnt_hs - b_hs) < v.k) && (!v.stall || phase);
      phase = !phase;
      if (lat == v.busy_rel) mmu_busy = 1'b0;
      @(negedge clk);
      lat++;
    end
    op_valid = 1'b0;
    mmu_busy = 1'b0;
    check_int({nm, "_res_valid"}, int'(res_valid), 1);
    if (v.lat >= 0) check_int({nm, "_latency"}, lat, v.lat);
    check_vec({nm, "_result"}, res_data, v.exp);
    held = res_data;
    unstable = 0;
    for (int i = 0; i < v.ready_delay; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== held || job_ready !== 1'b0) unstable++;
    end
    if (v.ready_delay > 0) check_int({nm, "_hold_stable"}, unstable, 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_int({nm, "_handoff"}, int'({res_valid, job_ready, seq_busy}), 2);
    check_int({nm, "_beats"}, cnt_hs - b_hs, v.k);
    check_int({nm, "_trigger_last"}, cnt_tl - b_tl, (v.k > 0) ? 1 : 0);
    check_int({nm, "_trigger"}, cnt_t - b_t, (v.k > 0) ? v.k - 1 : 0);
    check_int({nm, "_forward"}, cnt_f - b_f, (v.k > 0) ? 6 : 0);
    check_int({nm, "_reset_count"}, cnt_r - b_r, 1);
    check_int({nm, "_set_pe"}, cnt_s - b_s, PRE);
    check_int({nm, "_bus_errors"}, bad_gap + bad_fwd - b_bad, 0);
    if (v.k == 0) check_int({nm, "_op_ready_cycles"}, cnt_opr - b_opr, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; job_valid = 1'b0; job_k = '0; job_bias = '0;
    op_valid = 1'b0; op_data = '0; op_weight = '0;
    mmu_busy = 1'b0; res_ready = 1'b0;

    vecs[0] = '{k: 4, d: {4{32'd1}}, w: {4{32'd1}}, stall: 1'b0, ready_delay: 0,
                busy_rel: 0, exp: {16{32'd4}}, lat: 14 + PRE};
    vecs[1] = '{k: 1, d: {32'd4, 32'd3, 32'd2, 32'd1}, w: {32'd8, 32'd7, 32'd6, 32'd5},
                stall: 1'b0, ready_delay: 0, busy_rel: 0,
                exp: {32'd32, 32'd24, 32'd16, 32'd8, 32'd28, 32'd21, 32'd14, 32'd7,
                      32'd24, 32'd18, 32'd12, 32'd6, 32'd20, 32'd15, 32'd10, 32'd5},
                lat: 11 + PRE};
    vecs[2] = '{k: 8, d: {32'd4, 32'd3, 32'd2, 32'd1}, w: {4{32'd1}}, stall: 1'b1,
                ready_delay: 0, busy_rel: 0,
                exp: {4{32'd32, 32'd24, 32'd16, 32'd8}}, lat: -1};
    vecs[3] = '{k: 2, d: {4{32'd1}}, w: {4{32'd1}}, stall: 1'b0, ready_delay: 20,
                busy_rel: 0, exp: {16{32'd2}}, lat: 12 + PRE};
    vecs[4] = '{k: 0, d: {4{32'd1}}, w: {4{32'd1}}, stall: 1'b0, ready_delay: 0,
                busy_rel: 0, exp: '0, lat: 3 + PRE};
    vecs[5] = '{k: 1, d: {4{32'd1}}, w: {4{32'd1}}, stall: 1'b0, ready_delay: 0,
                busy_rel: 15, exp: {16{32'd1}}, lat: 16};
    vecs[6] = '{k: 2, d: {4{32'd1}}, w: {4{32'd1}}, stall: 1'b0, ready_delay: 0,
                busy_rel: 0, exp: {16{32'd2}}, lat: 12 + PRE};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i], i);

    // Abort a K=6 job after two accepted beats.
    @(negedge clk);
    n = cnt_hs;
    job_k = 16'd6; op_data = {4{32'd1}}; op_weight = {4{32'd1}};
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    op_valid = 1'b1;
    for (int i = 0; i < 50 && (cnt_hs - n) < 2; i++) @(negedge clk);
    op_valid = 1'b0;
    check_int("abort_beats_before_reset", cnt_hs - n, 2);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_int("abort_no_partial", int'({res_valid, seq_busy, job_ready}), 1);

    run_job(vecs[6], 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
